// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory bus controller: FSM state encoding,
// word-alignment mask and the default watchdog limit.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT_R = 2'd2,
    RESP   = 2'd3
  } dmem_state_t;

  // Clears the byte offset so the memory always sees a word address.
  localparam logic [31:0] DMEM_WORD_ALIGN = 32'hFFFF_FFFC;

  localparam int DMEM_TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/dmem_watchdog.sv
// Access watchdog: counts cycles while run is high, restarts on start and
// flags expired once the configured limit has been spent.
module dmem_watchdog
  import dmem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DMEM_TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic run,
  output logic expired
);

  // The count saturates at the limit so expired stays asserted until restart.
  localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] cnt_q;

  // Cycle counter, cleared on every new access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (start) begin
      cnt_q <= '0;
    end else if (run && (cnt_q != LIMIT)) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign expired = run && (cnt_q == LIMIT);

endmodule

// File: rtl/dmem_bus_ctrl.sv
// Data-memory bus controller between the MEM stage and a gnt/rvalid memory
// port. One access in flight; stalls the pipeline via req_ready.
// Optional feature: define DMEM_TIMEOUT_EN to enable the access watchdog,
// which completes a stuck access with rsp_err=1 after TIMEOUT_CYCLES.
module dmem_bus_ctrl
  import dmem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DMEM_TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wmask,
  output logic        req_ready,
  input  logic        flush,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  dmem_state_t state_q, state_d;

  logic        accept;
  logic        kill_q;
  logic        kill_set;
  logic [31:0] rdata_q;
  logic        rdata_cap;
  logic        tmo;
  logic        zero_rdata;

  // Request fields are captured on acceptance only; outputs are gated by
  // state, so these need no reset.
  logic        we_q;
  logic        noop_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;

  assign accept = (state_q == IDLE) && req_valid;

`ifdef DMEM_TIMEOUT_EN
  logic err_q;
  logic err_set;

  dmem_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (accept),
    .run    ((state_q == REQ) || (state_q == WAIT_R)),
    .expired(tmo)
  );

  // A timeout only reports an error when it is what ends a live access.
  assign err_set = tmo &&
                   (((state_q == REQ) && !noop_q && !mem_gnt && !flush) ||
                    ((state_q == WAIT_R) && !mem_rvalid && !kill_q && !flush));

  // Error flag for the current access, cleared by the next acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= 1'b0;
    end else if (err_set) begin
      err_q <= 1'b1;
    end
  end

  assign zero_rdata = we_q | err_q;
  assign rsp_err    = rsp_valid & err_q;
`else
  assign tmo        = 1'b0;
  assign zero_rdata = we_q;
  assign rsp_err    = 1'b0;
`endif

  // Capture the request on acceptance; the address is forced to a word.
  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= req_we;
      noop_q  <= req_we && (req_wmask == 4'b0000);
      addr_q  <= req_addr & DMEM_WORD_ALIGN;
      wdata_q <= req_wdata;
      be_q    <= req_wmask;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a killed access still finishes its bus handshake but
  // never reaches RESP.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) state_d = REQ;
      end
      REQ: begin
        if (noop_q) begin
          state_d = flush ? IDLE : RESP;
        end else if (mem_gnt) begin
          if (we_q) state_d = flush ? IDLE : RESP;
          else      state_d = WAIT_R;
        end else if (flush) begin
          state_d = IDLE;
        end else if (tmo) begin
          state_d = RESP;
        end
      end
      WAIT_R: begin
        if (mem_rvalid || tmo) state_d = (kill_q || flush) ? IDLE : RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A flush that lands on the grant or during WAIT_R leaves the read to drain.
  assign kill_set = flush &&
                    (((state_q == REQ) && mem_gnt) || (state_q == WAIT_R));

  // Kill marker for the in-flight load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kill_q <= 1'b0;
    end else if (accept) begin
      kill_q <= 1'b0;
    end else if (kill_set) begin
      kill_q <= 1'b1;
    end
  end

  assign rdata_cap = (state_q == WAIT_R) && mem_rvalid && !kill_q && !flush;

  // Load return data; held until the next completing load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (rdata_cap) begin
      rdata_q <= mem_rdata;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign mem_req   = (state_q == REQ) && !noop_q;
  assign mem_we    = mem_req & we_q;
  assign mem_addr  = mem_req ? addr_q  : '0;
  assign mem_wdata = mem_req ? wdata_q : '0;
  assign mem_be    = mem_req ? be_q    : '0;
  assign rsp_valid = (state_q == RESP) && !flush;
  assign rsp_rdata = ((state_q == RESP) && zero_rdata) ? '0 : rdata_q;

endmodule

// File: doc/dmem_bus_ctrl.md
DMEM_BUS_CTRL -- requirements
Module: dmem_bus_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: watchdog limit in cycles, range 1..65535.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL have port req_valid, input, 1: MEM-stage access request.
REQ-005 SHALL have port req_we, input, 1: 1 = store, 0 = load.
REQ-006 SHALL have port req_addr, input, 32: byte address.
REQ-007 SHALL have port req_wdata, input, 32: store data, already lane-aligned by the load/store aligner.
REQ-008 SHALL have port req_wmask, input, 4: byte enables from the load/store aligner.
REQ-009 SHALL have port req_ready, output, 1: request accepted this cycle; low means stall the pipeline.
REQ-010 SHALL have port flush, input, 1: pipeline kill of the in-flight access.
REQ-011 SHALL have port rsp_valid, output, 1: one-cycle completion pulse.
REQ-012 SHALL have port rsp_rdata, output, 32: raw memory word; feeds the aligner read input.
REQ-013 SHALL have port rsp_err, output, 1: timeout error, qualified by rsp_valid.
REQ-014 SHALL have ports mem_req (output, 1), mem_we (output, 1), mem_addr (output, 32), mem_wdata (output, 32), mem_be (output, 4): memory request channel.
REQ-015 SHALL have ports mem_gnt (input, 1), mem_rvalid (input, 1), mem_rdata (input, 32): memory grant and read-return channel.

Function
REQ-016 SHALL implement states IDLE, REQ, WAIT_R, RESP.
REQ-017 SHALL drive req_ready=1 only in IDLE; acceptance occurs when req_valid & req_ready.
REQ-018 SHALL on acceptance register req_we, req_wdata and req_wmask, store {req_addr[31:2],2'b00}, and enter REQ.
REQ-019 SHALL in REQ hold mem_req=1 with mem_we, mem_addr, mem_wdata and mem_be stable until mem_gnt=1.
REQ-020 SHALL, on mem_gnt in REQ: for a store, go to RESP; for a load, go to WAIT_R.
REQ-021 SHALL in WAIT_R capture mem_rdata into rsp_rdata on mem_rvalid and enter RESP.
REQ-022 SHALL ignore mem_rvalid in any state other than WAIT_R, including the grant cycle.
REQ-023 SHALL in RESP assert rsp_valid for exactly one cycle, then return to IDLE.
REQ-024 SHALL produce minimum latency, acceptance edge to rsp_valid: store 2 cycles, load 3 cycles.
REQ-025 SHALL drive rsp_rdata=0 for store completions.
REQ-026 SHALL hold rsp_rdata stable until the next load completes.
REQ-027 SHALL treat a store with req_wmask=0 as a no-op: skip the memory, go to RESP directly.
REQ-028 SHALL, when flush is asserted in REQ before grant, drop mem_req the next cycle and return to IDLE with no rsp_valid.
REQ-029 SHALL, when flush is asserted in REQ in the same cycle as mem_gnt, complete the granted access without rsp_valid: a load drains its rvalid, a store goes straight to IDLE.
REQ-030 SHALL, when flush is asserted in WAIT_R, absorb the pending rvalid, then return to IDLE without rsp_valid.
REQ-031 SHALL, when flush is asserted in RESP, suppress rsp_valid.
REQ-032 SHALL ignore flush in IDLE.

Reset
REQ-033 SHALL on rst_n low force IDLE, with req_ready=1 once released and all other outputs 0.
REQ-034 SHALL, if reset occurs mid-access, abandon the access; any later mem_rvalid is ignored per REQ-022.

Configuration
REQ-035 SHALL, with DMEM_TIMEOUT_EN defined, count cycles spent in REQ plus WAIT_R; on reaching TIMEOUT_CYCLES it enters RESP with rsp_err=1 and rsp_rdata=0.
REQ-036 SHALL, with DMEM_TIMEOUT_EN defined, restart the count on every acceptance.
REQ-037 SHALL, without DMEM_TIMEOUT_EN, wait indefinitely, tie rsp_err to 0, and instantiate no counter logic.

Structure
REQ-038 SHALL place the state enum, the DMEM_WORD_ALIGN mask and the default TIMEOUT_CYCLES in shared package dmem_pkg.
REQ-039 SHALL implement the watchdog as sub-module dmem_watchdog (inputs start/run, output expired), instantiated only under DMEM_TIMEOUT_EN.

Verification
REQ-040 Bench SHALL cover: load to 0x0000_1006, gnt same cycle as mem_req, rvalid one cycle later with 0xDEADBEEF -> mem_addr=0x0000_1004, rsp_valid 3 cycles after acceptance, rsp_rdata=0xDEADBEEF.
REQ-041 Bench SHALL cover: store wdata 0x0000_AB00, wmask 4'b0010, gnt delayed 4 cycles -> mem_req held 5 cycles, mem_be=4'b0010 stable throughout, rsp_valid with rdata 0.
REQ-042 Bench SHALL cover: store with wmask=0 -> no mem_req ever, rsp_valid 2 cycles after acceptance.
REQ-043 Bench SHALL cover: flush in REQ before grant -> mem_req low next cycle, no rsp_valid, req_ready=1 the following cycle.
REQ-044 Bench SHALL cover: flush in WAIT_R, rvalid 2 cycles later -> no rsp_valid, IDLE after rvalid, next load returns its own data.
REQ-045 Bench SHALL cover: with DMEM_TIMEOUT_EN and TIMEOUT_CYCLES=8, no gnt -> rsp_valid and rsp_err=1 after 8 cycles; rst_n pulse mid-REQ -> all outputs 0 immediately.
